// File: rtl/ftq_commit_buffer_if.sv
// Frontend/ROB-facing bundle of the FTQ commit buffer.
// The master side drives requests, and the slave side (the buffer) answers them.
interface ftq_commit_buffer_if #(
  parameter int unsigned FTQ_SIZE = 32,
  parameter int unsigned XLEN     = 64
);
  localparam int unsigned IW = $clog2(FTQ_SIZE);

  logic            i_enq_vld;
  logic [XLEN-1:0] i_enq_startAddr;
  logic            o_enq_rdy;
  logic [IW-1:0]   o_enq_ftqIdx;
  logic            i_commit_vld;
  logic [IW-1:0]   i_commit_ftq_idx;
  logic            i_read_ftq_vld;
  logic [IW-1:0]   i_read_ftqIdx;
  logic [XLEN-1:0] o_read_ftqStartAddr;
  logic            i_squash_vld;
  logic [IW:0]     o_count;
  logic            o_empty;
  logic            o_full;

  modport master (
    output i_enq_vld, i_enq_startAddr, i_commit_vld, i_commit_ftq_idx,
           i_read_ftq_vld, i_read_ftqIdx, i_squash_vld,
    input  o_enq_rdy, o_enq_ftqIdx, o_read_ftqStartAddr, o_count, o_empty, o_full
  );

  modport slave (
    input  i_enq_vld, i_enq_startAddr, i_commit_vld, i_commit_ftq_idx,
           i_read_ftq_vld, i_read_ftqIdx, i_squash_vld,
    output o_enq_rdy, o_enq_ftqIdx, o_read_ftqStartAddr, o_count, o_empty, o_full
  );
endinterface

// File: rtl/ftq_commit_buffer.sv
// Commit-side FTQ slice: stores fetch-block start PCs, serves ROB reads,
// retires entries behind the commit threshold and rewinds on squash.
module ftq_commit_buffer #(
  parameter int unsigned FTQ_SIZE = 32,
  parameter int unsigned XLEN     = 64
) (
  input  logic                clk,
  input  logic                rst,
  ftq_commit_buffer_if.slave  bus
);
  localparam int unsigned IW = $clog2(FTQ_SIZE);
  localparam int unsigned PW = IW + 1;

  // Pointers are {flip, idx}; plain PW-bit increment wraps idx and toggles flip.
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   thre_q, thre_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] mem [FTQ_SIZE];

  logic [PW-1:0]   thre_cmt;
  logic [PW-1:0]   dist_old;
  logic [PW-1:0]   dist_new;
  logic [PW-1:0]   count;
  logic [PW-1:0]   rd_off;
  logic            full;
  logic            enq_fire;
  logic            cmt_ok;

  always_comb begin
    count    = tail_q - head_q;
    full     = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    enq_fire = bus.i_enq_vld && !full && !bus.i_squash_vld;

    // A threshold index below head's index must lie in the next lap.
    thre_cmt = {(bus.i_commit_ftq_idx >= head_q[IW-1:0]) ? head_q[IW] : !head_q[IW],
                bus.i_commit_ftq_idx};
    dist_old = thre_q - head_q;
    dist_new = thre_cmt - head_q;
    cmt_ok   = bus.i_commit_vld && (dist_new >= dist_old);
    thre_d   = cmt_ok ? thre_cmt : thre_q;

    head_d = (head_q != thre_q) ? head_q + PW'(1) : head_q;

    tail_d = tail_q;
    if (bus.i_squash_vld) begin
      tail_d = thre_d;
    end else if (enq_fire) begin
      tail_d = tail_q + PW'(1);
    end

    rdata_d = bus.i_read_ftq_vld ? mem[bus.i_read_ftqIdx] : rdata_q;
    rd_off  = {1'b0, IW'(bus.i_read_ftqIdx - head_q[IW-1:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      thre_q  <= '0;
      rdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      thre_q  <= thre_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      mem[tail_q[IW-1:0]] <= bus.i_enq_startAddr;
    end
  end

  assign bus.o_enq_rdy           = !full && !bus.i_squash_vld;
  assign bus.o_enq_ftqIdx        = tail_q[IW-1:0];
  assign bus.o_read_ftqStartAddr = rdata_q;
  assign bus.o_count             = count;
  assign bus.o_empty             = (head_q == tail_q);
  assign bus.o_full              = full;

  // Protocol checks on ROB-side requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.i_commit_vld) begin
        assert (dist_new >= dist_old) else $error("ftq: commit threshold moved backwards");
        assert (dist_new <= count) else $error("ftq: commit threshold beyond tail");
      end
      if (bus.i_read_ftq_vld) begin
        assert (rd_off < count) else $error("ftq: read of a non-live entry");
      end
    end
  end
endmodule

// File: tb/tb_ftq_commit_buffer.sv
// Self-checking bench for ftq_commit_buffer: vector rows plus a read-data scoreboard.
module tb_ftq_commit_buffer;
  localparam int unsigned N    = 32;
  localparam int unsigned XLEN = 64;

  typedef struct {
    logic        rst;
    logic        enq;
    logic [63:0] addr;
    logic        cmt;
    logic [4:0]  cidx;
    logic        rd;
    logic [4:0]  ridx;
    logic        sq;
    logic [4:0]  e_idx;
    logic [5:0]  e_cnt;
    logic        e_empty;
    logic        e_full;
    logic        e_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftq_commit_buffer_if #(.FTQ_SIZE(N), .XLEN(XLEN)) bus ();
  ftq_commit_buffer #(.FTQ_SIZE(N), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          ntests = 0;
  int          nfail  = 0;
  int          stepn  = 0;
  logic [63:0] mem_m [N];
  logic [63:0] rd_q [$];
  logic [63:0] rd_exp = '0;
  vec_t        tbl [$];

  function automatic vec_t mk(input logic enq, input logic [63:0] addr, input logic cmt,
                              input int cidx, input logic rd, input int ridx, input logic sq,
                              input int e_idx, input int e_cnt);
    vec_t v;
    v.rst     = 1'b0;
    v.enq     = enq;
    v.addr    = addr;
    v.cmt     = cmt;
    v.cidx    = 5'(cidx);
    v.rd      = rd;
    v.ridx    = 5'(ridx);
    v.sq      = sq;
    v.e_idx   = 5'(e_idx);
    v.e_cnt   = 6'(e_cnt);
    v.e_empty = (e_cnt == 0);
    v.e_full  = (e_cnt == N);
    v.e_rdy   = !v.e_full && !sq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", nm, stepn, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst;
    bus.i_enq_vld        = v.enq;
    bus.i_enq_startAddr  = v.addr;
    bus.i_commit_vld     = v.cmt;
    bus.i_commit_ftq_idx = v.cidx;
    bus.i_read_ftq_vld   = v.rd;
    bus.i_read_ftqIdx    = v.ridx;
    bus.i_squash_vld     = v.sq;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, then check read data after the edge.
  task automatic step(input vec_t v);
    stepn++;
    drive(v);
    @(negedge clk);
    chk("enq_ftqIdx", 64'(bus.o_enq_ftqIdx), 64'(v.e_idx));
    chk("count", 64'(bus.o_count), 64'(v.e_cnt));
    chk("empty", 64'(bus.o_empty), 64'(v.e_empty));
    chk("full", 64'(bus.o_full), 64'(v.e_full));
    chk("enq_rdy", 64'(bus.o_enq_rdy), 64'(v.e_rdy));
    if (v.rst) begin
      rd_q.delete();
      rd_exp = '0;
    end else begin
      if (v.rd) rd_q.push_back(mem_m[v.ridx]);
      if (v.enq && v.e_rdy) mem_m[v.e_idx] = v.addr;
    end
    @(posedge clk);
    #1;
    if (rd_q.size() > 0) rd_exp = rd_q.pop_front();
    chk("read_startAddr", bus.o_read_ftqStartAddr, rd_exp);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    drive(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_q.delete();
    rd_exp = '0;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < N; i++) mem_m[i] = '0;

    // Enqueue ramp, threshold 3, then commit 6 together with squash.
    tbl.push_back(mk(1, 64'h1000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h1010, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 64'h1020, 0, 0, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 64'h1030, 1, 3, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 64'h1040, 0, 0, 0, 0, 0, 4, 4));
    tbl.push_back(mk(1, 64'h1050, 0, 0, 1, 2, 0, 5, 4));
    tbl.push_back(mk(1, 64'h1060, 0, 0, 0, 0, 0, 6, 4));
    tbl.push_back(mk(1, 64'h1070, 0, 0, 0, 0, 0, 7, 4));
    tbl.push_back(mk(1, 64'h1080, 0, 0, 0, 0, 0, 8, 5));
    tbl.push_back(mk(1, 64'h1090, 0, 0, 0, 0, 0, 9, 6));
    tbl.push_back(mk(1, 64'hdead, 1, 6, 0, 0, 1, 10, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 6, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 6, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 0));

    do_reset();
    foreach (tbl[i]) step(tbl[i]);

    // Fill to full, blocked 33rd enqueue, then commit 4 drains one per cycle.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 32; i++) step(mk(1, 64'h2000 + 64'(i * 16), 0, 0, 0, 0, 0, i, i));
    step(mk(1, 64'hbad, 0, 0, 0, 0, 0, 0, 32));
    step(mk(0, 0, 1, 4, 0, 0, 0, 0, 32));
    step(mk(1, 64'hbad0, 0, 0, 0, 0, 0, 0, 32));
    for (int k = 1; k <= 4; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 32 - k));
    step(mk(0, 0, 0, 0, 1, 4, 0, 0, 28));

    // Read data lands one cycle after the request and holds without further reads.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(mk(1, (i == 7) ? 64'h8000 : 64'h3000 + 64'(i), 0, 0, 0, 0, 0, i, i));
    step(mk(0, 0, 0, 0, 1, 7, 0, 8, 8));
    for (int k = 0; k < 5; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 8, 8));

    // Wrap: head at 30, threshold 2 lies in the next lap.
    do_reset();
    for (int i = 0; i < 30; i++) step(mk(1, 64'h4000 + 64'(i * 4), 0, 0, 0, 0, 0, i, i));
    step(mk(0, 0, 1, 30, 0, 0, 0, 30, 30));
    for (int k = 0; k <= 30; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 30, 30 - k));
    for (int j = 0; j < 6; j++) step(mk(1, 64'h5000 + 64'(j), 0, 0, 0, 0, 0, (30 + j) % 32, j));
    step(mk(0, 0, 1, 2, 1, 1, 0, 4, 6));
    for (int k = 0; k < 6; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 4, (6 - k > 2) ? 6 - k : 2));

    // Reset mid-operation with head 5, tail 12 and a read in flight.
    do_reset();
    for (int i = 0; i < 12; i++) step(mk(1, 64'h6000 + 64'(i), 0, 0, 0, 0, 0, i, i));
    step(mk(0, 0, 1, 5, 0, 0, 0, 12, 12));
    for (int k = 0; k < 5; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 12, 12 - k));
    step(mk(0, 0, 0, 0, 1, 8, 0, 12, 7));
    v = mk(0, 0, 0, 0, 1, 9, 0, 12, 7);
    v.rst = 1'b1;
    step(v);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ftq_commit_buffer.md
Name: ftq_commit_buffer

Overview:
Commit-side slice of the fetch target queue. It stores one start address per fetch block and hands out ftq indices at enqueue. It answers the ROB's trap-time start-address read and retires entries behind the ROB's commit threshold. On a pipeline squash it rewinds its allocation pointer to the commit threshold.

Parameters:
FTQ_SIZE, 32, number of entries; must be a power of two, at least 4.
XLEN, 64, address width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_enq_vld  in  1  frontend allocates a new fetch block
i_enq_startAddr  in  XLEN  start PC of the new block
o_enq_rdy  out  1  entry available; enqueue accepted when i_enq_vld && o_enq_rdy
o_enq_ftqIdx  out  log2(FTQ_SIZE)  index assigned to the current enqueue (the tail index)
i_commit_vld  in  1  ROB commit notification
i_commit_ftq_idx  in  log2(FTQ_SIZE)  new commit threshold; all entries strictly older than it are retirable
i_read_ftq_vld  in  1  ROB start-address read request
i_read_ftqIdx  in  log2(FTQ_SIZE)  entry to read
o_read_ftqStartAddr  out  XLEN  read data, registered
i_squash_vld  in  1  pipeline squash from ROB
o_count  out  log2(FTQ_SIZE)+1  number of live entries (head to tail)
o_empty  out  1  head == tail, flip bits equal
o_full  out  1  indices equal, flip bits differ

Behaviour:
- Pointers: head, tail and thre are each {flip, idx}; idx wraps at FTQ_SIZE-1 -> 0 and the flip bit toggles on wrap.
- Reset: all pointers 0, flips 0. o_read_ftqStartAddr=0, o_count=0, o_empty=1, o_full=0, o_enq_rdy=1. Storage contents are not reset.
- Enqueue:
  - o_enq_rdy = !full && !i_squash_vld.
  - On an accepted enqueue: mem[tail.idx] <= i_enq_startAddr, tail++.
  - o_enq_ftqIdx = tail.idx combinationally.
- Commit:
  - On i_commit_vld: thre.idx <= i_commit_ftq_idx.
  - thre.flip = head.flip if i_commit_ftq_idx >= head.idx, else !head.flip.
  - A threshold that does not advance (distance from head shrinks) is ignored; an assertion flags it.
  - A threshold beyond tail is illegal; an assertion flags it.
- Dequeue:
  - Each cycle with head != thre: head++ (one entry freed per cycle). Freeing lags the threshold update by at least 1 cycle.
  - Dequeue is evaluated against the registered thre, so a threshold written in cycle N can first free an entry in cycle N+1.
  - Dequeue continues in the squash cycle.
- Read:
  - i_read_ftq_vld in cycle N -> o_read_ftqStartAddr = mem[i_read_ftqIdx] from cycle N+1.
  - The value holds until the next read request.
  - Enqueue to the same index in cycle N does not bypass; the old value is returned.
  - Reading an index outside [head, tail) returns the stale contents; an assertion flags it.
- Squash:
  - On i_squash_vld: tail <= next-thre. Next-thre is the newly written threshold if i_commit_vld is also high this cycle, otherwise the registered thre.
  - Every entry at or younger than the threshold is discarded. head, thre and memory are unchanged.
- Simultaneous events:
  - Commit and squash in the same cycle: the commit is applied first, then tail rewinds to the new threshold.
  - Enqueue and dequeue in the same cycle: count is unchanged.
  - Full blocks enqueue even if a dequeue happens in the same cycle; o_enq_rdy is computed from the registered pointers.
- o_count = tail - head over {flip, idx}, modulo 2*FTQ_SIZE. o_count, o_empty and o_full are combinational from the registered pointers.
- Reset mid-operation clears the pointers; a pending read response is cleared to 0 on the next cycle.

Test Plan:
- Reset, then enqueue 0x1000, 0x1010, 0x1020 on consecutive cycles -> o_enq_ftqIdx = 0, 1, 2; o_count = 3; o_empty = 0.
- Enqueue 32 blocks without commit -> o_full = 1, o_enq_rdy = 0, the 33rd enqueue is ignored. Then commit idx = 4 -> head advances 1 per cycle to 4 over 4 cycles; o_count goes 32 -> 28; o_enq_rdy = 1 after the first free.
- Enqueue 0x8000 at idx 7; read request idx 7 in cycle N -> o_read_ftqStartAddr = 0x8000 in cycle N+1 and held through N+5 with no further reads.
- Entries 0..9 live, thre = 3. Assert i_squash_vld with i_commit_vld and i_commit_ftq_idx = 6 in the same cycle -> next cycle tail = 6, o_enq_ftqIdx = 6, head drains to 6, o_count ends at 0.
- Wrap: cycle head/tail through index 31 -> 0. Commit threshold 2 while head = 30 -> thre.flip = !head.flip, head frees 30, 31, 0, 1 and stops at 2 with o_count correct.
- Assert rst while head = 5, tail = 12 -> next cycle o_count = 0, o_empty = 1, o_read_ftqStartAddr = 0, o_enq_ftqIdx = 0.
